// File: rtl/sys_pkg.sv
// Shared definitions for the UART command link: frame opcodes, command
// encodings, controller states and per-command frame/response lengths.
package sys_pkg;

  localparam logic [7:0] FRM_WR  = 8'hAA;
  localparam logic [7:0] FRM_RD  = 8'hBB;
  localparam logic [7:0] FRM_ALU = 8'hCC;
  localparam logic [7:0] FRM_NOP = 8'hDD;

  typedef enum logic [1:0] {
    CMD_WR  = 2'b00,
    CMD_RD  = 2'b01,
    CMD_ALU = 2'b10,
    CMD_NOP = 2'b11
  } cmd_type_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_RSP,
    ST_DONE
  } state_e;

  // Number of bytes sent toward UART TX for a command.
  function automatic logic [2:0] tx_len(input cmd_type_e t);
    case (t)
      CMD_WR:  tx_len = 3'd3;
      CMD_RD:  tx_len = 3'd2;
      CMD_ALU: tx_len = 3'd4;
      default: tx_len = 3'd2;
    endcase
  endfunction

  // Number of response bytes expected back over UART RX.
  function automatic logic [1:0] rsp_len(input cmd_type_e t);
    case (t)
      CMD_WR:  rsp_len = 2'd0;
      CMD_RD:  rsp_len = 2'd1;
      default: rsp_len = 2'd2;
    endcase
  endfunction

endpackage

// File: rtl/sys_cmd_host_rsp_timeout_cnt.sv
// Idle-gap counter for the response phase: cleared by the host, counts while
// enabled and raises expired once it has sat at TIMEOUT_CYCLES-1.
module rsp_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES)
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) cnt_d = '0;
    else if (enable && !expired) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sys_cmd_host.sv
// Host end of the UART command link: serializes one command into byte frames
// toward UART TX and assembles the returned response bytes into one word.
module sys_cmd_host
  import sys_pkg::*;
#(
  parameter int FRAME_WIDTH         = 8,
  parameter int ALU_DATA_WIDTH      = 16,
  parameter int ALU_FUNC_WIDTH      = 4,
  parameter int REG_FILE_ADDR_WIDTH = 4,
  parameter int TIMEOUT_CYCLES      = 1024
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           CMD_VLD,
  output logic                           CMD_RDY,
  input  logic [1:0]                     CMD_TYPE,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] CMD_ADDR,
  input  logic [FRAME_WIDTH-1:0]         CMD_WDATA,
  input  logic [FRAME_WIDTH-1:0]         CMD_OPB,
  input  logic [ALU_FUNC_WIDTH-1:0]      CMD_FUNC,
  output logic [FRAME_WIDTH-1:0]         TX_P_DATA,
  output logic                           TX_D_VLD,
  input  logic                           TX_BUSY,
  input  logic [FRAME_WIDTH-1:0]         RX_P_DATA,
  input  logic                           RX_P_VLD,
  output logic                           RSP_VLD,
  output logic [ALU_DATA_WIDTH-1:0]      RSP_DATA,
  output logic                           RSP_ERR,
  output logic                           BUSY
);

  state_e                           state_q, state_d;
  cmd_type_e                        type_q, type_d;
  logic [REG_FILE_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [FRAME_WIDTH-1:0]           wdata_q, wdata_d;
  logic [FRAME_WIDTH-1:0]           opb_q, opb_d;
  logic [ALU_FUNC_WIDTH-1:0]        func_q, func_d;
  logic [2:0]                       idx_q, idx_d;
  logic [1:0]                       rx_cnt_q, rx_cnt_d;
  logic [ALU_DATA_WIDTH-1:0]        rx_buf_q, rx_buf_d, rx_buf_nx;
  logic [FRAME_WIDTH-1:0]           tx_data_q, tx_data_d;
  logic                             tx_vld_q, tx_vld_d;
  logic                             rsp_vld_q, rsp_vld_d;
  logic [ALU_DATA_WIDTH-1:0]        rsp_data_q, rsp_data_d;
  logic                             rsp_err_q, rsp_err_d;
  logic                             cmd_rdy_q, cmd_rdy_d;
  logic                             busy_q, busy_d;
  logic                             to_expired;

  // Byte i of the frame sequence; addr/func are zero-extended to a frame.
  function automatic logic [FRAME_WIDTH-1:0] frame_byte(
    input cmd_type_e                      t,
    input logic [2:0]                     i,
    input logic [REG_FILE_ADDR_WIDTH-1:0] a,
    input logic [FRAME_WIDTH-1:0]         wd,
    input logic [FRAME_WIDTH-1:0]         ob,
    input logic [ALU_FUNC_WIDTH-1:0]      fn
  );
    logic [FRAME_WIDTH-1:0] r;
    r = '0;
    case (t)
      CMD_WR:  case (i)
                 3'd0:    r = FRAME_WIDTH'(FRM_WR);
                 3'd1:    r = FRAME_WIDTH'(a);
                 default: r = wd;
               endcase
      CMD_RD:  r = (i == 3'd0) ? FRAME_WIDTH'(FRM_RD) : FRAME_WIDTH'(a);
      CMD_ALU: case (i)
                 3'd0:    r = FRAME_WIDTH'(FRM_ALU);
                 3'd1:    r = wd;
                 3'd2:    r = ob;
                 default: r = FRAME_WIDTH'(fn);
               endcase
      default: r = (i == 3'd0) ? FRAME_WIDTH'(FRM_NOP) : FRAME_WIDTH'(fn);
    endcase
    return r;
  endfunction

  // Counter is held clear outside the response phase, so it starts at 0 on entry.
  rsp_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .CLK     (CLK),
    .RST     (RST),
    .clear   ((state_q != ST_WAIT_RSP) || RX_P_VLD),
    .enable  (state_q == ST_WAIT_RSP),
    .expired (to_expired)
  );

  always_comb begin
    state_d    = state_q;
    type_d     = type_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    opb_d      = opb_q;
    func_d     = func_q;
    idx_d      = idx_q;
    rx_cnt_d   = rx_cnt_q;
    rx_buf_d   = rx_buf_q;
    tx_data_d  = tx_data_q;
    tx_vld_d   = tx_vld_q;
    rsp_vld_d  = 1'b0;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    cmd_rdy_d  = cmd_rdy_q;
    busy_d     = busy_q;
    rx_buf_nx  = rx_buf_q;
    if (rx_cnt_q == 2'd0) rx_buf_nx[FRAME_WIDTH-1:0] = RX_P_DATA;
    else                  rx_buf_nx[2*FRAME_WIDTH-1:FRAME_WIDTH] = RX_P_DATA;

    case (state_q)
      ST_IDLE: if (CMD_VLD) begin
        type_d    = cmd_type_e'(CMD_TYPE);
        addr_d    = CMD_ADDR;
        wdata_d   = CMD_WDATA;
        opb_d     = CMD_OPB;
        func_d    = CMD_FUNC;
        idx_d     = 3'd0;
        rx_cnt_d  = 2'd0;
        rx_buf_d  = '0;
        tx_data_d = frame_byte(cmd_type_e'(CMD_TYPE), 3'd0, CMD_ADDR, CMD_WDATA, CMD_OPB, CMD_FUNC);
        tx_vld_d  = 1'b1;
        cmd_rdy_d = 1'b0;
        busy_d    = 1'b1;
        state_d   = ST_SEND;
      end
      ST_SEND: if (!TX_BUSY) begin
        if (idx_q == tx_len(type_q) - 3'd1) begin
          tx_vld_d = 1'b0;
          if (type_q == CMD_WR) begin
            // rx_buf was cleared on accept, so a write reports zero data.
            rsp_vld_d  = 1'b1;
            rsp_data_d = rx_buf_q;
            rsp_err_d  = 1'b0;
            state_d    = ST_DONE;
          end else begin
            state_d = ST_WAIT_RSP;
          end
        end else begin
          idx_d     = idx_q + 3'd1;
          tx_data_d = frame_byte(type_q, idx_q + 3'd1, addr_q, wdata_q, opb_q, func_q);
        end
      end
      ST_WAIT_RSP: begin
        // An arriving byte takes priority over an expiry in the same cycle.
        if (RX_P_VLD) begin
          rx_buf_d = rx_buf_nx;
          rx_cnt_d = rx_cnt_q + 2'd1;
          if (rx_cnt_q + 2'd1 == rsp_len(type_q)) begin
            rsp_vld_d  = 1'b1;
            rsp_data_d = rx_buf_nx;
            rsp_err_d  = 1'b0;
            state_d    = ST_DONE;
          end
        end else if (to_expired) begin
          rsp_vld_d  = 1'b1;
          rsp_data_d = rx_buf_q;
          rsp_err_d  = 1'b1;
          state_d    = ST_DONE;
        end
      end
      default: begin
        cmd_rdy_d = 1'b1;
        busy_d    = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= ST_IDLE;
      type_q     <= CMD_WR;
      addr_q     <= '0;
      wdata_q    <= '0;
      opb_q      <= '0;
      func_q     <= '0;
      idx_q      <= '0;
      rx_cnt_q   <= '0;
      rx_buf_q   <= '0;
      tx_data_q  <= '0;
      tx_vld_q   <= 1'b0;
      rsp_vld_q  <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      cmd_rdy_q  <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      type_q     <= type_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      opb_q      <= opb_d;
      func_q     <= func_d;
      idx_q      <= idx_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_buf_q   <= rx_buf_d;
      tx_data_q  <= tx_data_d;
      tx_vld_q   <= tx_vld_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      cmd_rdy_q  <= cmd_rdy_d;
      busy_q     <= busy_d;
    end
  end

  assign CMD_RDY   = cmd_rdy_q;
  assign TX_P_DATA = tx_data_q;
  assign TX_D_VLD  = tx_vld_q;
  assign RSP_VLD   = rsp_vld_q;
  assign RSP_DATA  = rsp_data_q;
  assign RSP_ERR   = rsp_err_q;
  assign BUSY      = busy_q;

endmodule

// File: tb/tb_sys_cmd_host.sv
// Bench for sys_cmd_host: expected TX frames and responses are queued when a
// command is driven and compared as the DUT emits bytes and response pulses.
module tb_sys_cmd_host;

  localparam int TO = 16;

  logic        CLK;
  logic        RST;
  logic        CMD_VLD;
  logic        CMD_RDY;
  logic [1:0]  CMD_TYPE;
  logic [3:0]  CMD_ADDR;
  logic [7:0]  CMD_WDATA;
  logic [7:0]  CMD_OPB;
  logic [3:0]  CMD_FUNC;
  logic [7:0]  TX_P_DATA;
  logic        TX_D_VLD;
  logic        TX_BUSY;
  logic [7:0]  RX_P_DATA;
  logic        RX_P_VLD;
  logic        RSP_VLD;
  logic [15:0] RSP_DATA;
  logic        RSP_ERR;
  logic        BUSY;

  sys_cmd_host #(
    .FRAME_WIDTH(8), .ALU_DATA_WIDTH(16), .ALU_FUNC_WIDTH(4),
    .REG_FILE_ADDR_WIDTH(4), .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK(CLK), .RST(RST), .CMD_VLD(CMD_VLD), .CMD_RDY(CMD_RDY),
    .CMD_TYPE(CMD_TYPE), .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA),
    .CMD_OPB(CMD_OPB), .CMD_FUNC(CMD_FUNC), .TX_P_DATA(TX_P_DATA),
    .TX_D_VLD(TX_D_VLD), .TX_BUSY(TX_BUSY), .RX_P_DATA(RX_P_DATA),
    .RX_P_VLD(RX_P_VLD), .RSP_VLD(RSP_VLD), .RSP_DATA(RSP_DATA),
    .RSP_ERR(RSP_ERR), .BUSY(BUSY)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- scoreboard state ----------------
  logic [7:0]  exp_tx_q[$];
  logic [16:0] exp_rsp_q[$];
  logic [16:0] rsp_e;
  int n_cmp = 0;
  int n_err = 0;
  int neg_cyc = 0;
  int acc_cnt = 0;
  int acc_neg = 0;
  int rx_neg = 0;
  int rsp_neg = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor on the falling edge: inputs and outputs are stable here.
  always @(negedge CLK) begin
    neg_cyc++;
    if (RST) begin
      if (CMD_VLD && CMD_RDY) begin
        acc_cnt++;
        acc_neg = neg_cyc;
      end
      if (RX_P_VLD) rx_neg = neg_cyc;
      if (TX_D_VLD) begin
        if (exp_tx_q.size() == 0) check_val("tx_unexpected", {31'd0, TX_D_VLD}, 32'd0);
        else begin
          check_val("tx_byte", {24'd0, TX_P_DATA}, {24'd0, exp_tx_q[0]});
          if (!TX_BUSY) void'(exp_tx_q.pop_front());
        end
      end
      if (RSP_VLD) begin
        rsp_neg = neg_cyc;
        if (exp_rsp_q.size() == 0) check_val("rsp_unexpected", {31'd0, RSP_VLD}, 32'd0);
        else begin
          rsp_e = exp_rsp_q.pop_front();
          check_val("rsp_data", {16'd0, RSP_DATA}, {16'd0, rsp_e[15:0]});
          check_val("rsp_err", {31'd0, RSP_ERR}, {31'd0, rsp_e[16]});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_frames(input logic [1:0] t, input logic [3:0] a, input logic [7:0] wd,
                             input logic [7:0] ob, input logic [3:0] fn);
    case (t)
      2'b00: begin exp_tx_q.push_back(8'hAA); exp_tx_q.push_back({4'd0, a}); exp_tx_q.push_back(wd); end
      2'b01: begin exp_tx_q.push_back(8'hBB); exp_tx_q.push_back({4'd0, a}); end
      2'b10: begin
        exp_tx_q.push_back(8'hCC); exp_tx_q.push_back(wd);
        exp_tx_q.push_back(ob); exp_tx_q.push_back({4'd0, fn});
      end
      default: begin exp_tx_q.push_back(8'hDD); exp_tx_q.push_back({4'd0, fn}); end
    endcase
  endtask

  task automatic issue_cmd(input logic [1:0] t, input logic [3:0] a, input logic [7:0] wd,
                           input logic [7:0] ob, input logic [3:0] fn);
    bit got;
    push_frames(t, a, wd, ob, fn);
    @(posedge CLK); #1;
    CMD_TYPE = t; CMD_ADDR = a; CMD_WDATA = wd; CMD_OPB = ob; CMD_FUNC = fn;
    CMD_VLD = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge CLK);
      if (CMD_RDY) begin got = 1'b1; break; end
    end
    if (!got) check_val("accept_budget", {31'd0, CMD_RDY}, 32'd1);
    @(posedge CLK); #1;
    CMD_VLD = 1'b0;
    check_val("busy_after_acc", {31'd0, BUSY}, 32'd1);
    check_val("rdy_after_acc", {31'd0, CMD_RDY}, 32'd0);
  endtask

  task automatic send_rx(input logic [7:0] b);
    @(posedge CLK); #1;
    RX_P_DATA = b; RX_P_VLD = 1'b1;
    @(posedge CLK); #1;
    RX_P_VLD = 1'b0;
  endtask

  task automatic wait_tx_empty();
    for (int i = 0; i < 3000; i++) begin
      if (exp_tx_q.size() == 0) break;
      @(posedge CLK);
    end
    if (exp_tx_q.size() != 0) check_val("tx_drain_budget", exp_tx_q.size(), 32'd0);
  endtask

  task automatic wait_rsp_empty();
    for (int i = 0; i < 3000; i++) begin
      if (exp_rsp_q.size() == 0) break;
      @(posedge CLK);
    end
    if (exp_rsp_q.size() != 0) check_val("rsp_budget", exp_rsp_q.size(), 32'd0);
  endtask

  // Full command: queue frames and response, then answer with n_rx bytes.
  task automatic run_cmd(input logic [1:0] t, input logic [3:0] a, input logic [7:0] wd,
                         input logic [7:0] ob, input logic [3:0] fn, input int n_rx,
                         input logic [7:0] b0, input logic [7:0] b1);
    int need;
    logic [15:0] data;
    need = (t == 2'b00) ? 0 : (t == 2'b01) ? 1 : 2;
    data = 16'd0;
    if (n_rx >= 1 && need >= 1) data[7:0]  = b0;
    if (n_rx >= 2 && need >= 2) data[15:8] = b1;
    exp_rsp_q.push_back({(n_rx < need), data});
    issue_cmd(t, a, wd, ob, fn);
    wait_tx_empty();
    if (n_rx >= 1) send_rx(b0);
    if (n_rx >= 2) send_rx(b1);
    wait_rsp_empty();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int first_acc;
    int a0;
    RST = 1'b0; CMD_VLD = 1'b0; CMD_TYPE = '0; CMD_ADDR = '0; CMD_WDATA = '0;
    CMD_OPB = '0; CMD_FUNC = '0; TX_BUSY = 1'b0; RX_P_DATA = '0; RX_P_VLD = 1'b0;
    repeat (3) @(negedge CLK);
    check_val("rst_cmd_rdy", {31'd0, CMD_RDY}, 32'd1);
    check_val("rst_tx_vld", {31'd0, TX_D_VLD}, 32'd0);
    check_val("rst_tx_data", {24'd0, TX_P_DATA}, 32'd0);
    check_val("rst_rsp_vld", {31'd0, RSP_VLD}, 32'd0);
    check_val("rst_rsp_data", {16'd0, RSP_DATA}, 32'd0);
    check_val("rst_busy", {31'd0, BUSY}, 32'd0);
    @(posedge CLK); #1;
    RST = 1'b1;

    // Write, no backpressure.
    run_cmd(2'b00, 4'd5, 8'h3C, 8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)), 0, 8'h00, 8'h00);
    check_val("wr_latency", rsp_neg - acc_neg, 32'd4);

    // Stray byte in IDLE, then read under backpressure with a stray byte in SEND.
    send_rx(8'h55);
    exp_rsp_q.push_back({1'b0, 16'h007E});
    TX_BUSY = 1'b1;
    issue_cmd(2'b01, 4'd2, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 4'd0);
    for (int b = 0; b < 2; b++) begin
      if (b == 0) begin send_rx(8'h99); repeat (8) @(posedge CLK); end
      else repeat (10) @(posedge CLK);
      #1 TX_BUSY = 1'b0;
      @(posedge CLK); #1 TX_BUSY = 1'b1;
    end
    TX_BUSY = 1'b0;
    wait_tx_empty();
    send_rx(8'h7E);
    wait_rsp_empty();

    // ALU with operands, plus an extra byte after the response.
    run_cmd(2'b10, 4'd0, 8'h12, 8'h34, 4'd1, 2, 8'h46, 8'h00);
    send_rx(8'hEE);

    // NOP with only one response byte: times out.
    run_cmd(2'b11, 4'd0, 8'd0, 8'd0, 4'd8, 1, 8'hAB, 8'h00);
    check_val("to_latency", rsp_neg - rx_neg, 32'd17);

    // Read whose single byte lands on the expiry cycle.
    exp_rsp_q.push_back({1'b0, 16'h00C3});
    issue_cmd(2'b01, 4'hA, 8'd0, 8'd0, 4'd0);
    repeat (17) @(posedge CLK);
    #1 RX_P_DATA = 8'hC3; RX_P_VLD = 1'b1;
    @(posedge CLK); #1 RX_P_VLD = 1'b0;
    wait_rsp_empty();
    check_val("expiry_rx_lat", rsp_neg - rx_neg, 32'd1);

    // CMD_VLD held through BUSY: second write accepted only back in IDLE.
    push_frames(2'b00, 4'd7, 8'h81, 8'd0, 4'd0);
    exp_rsp_q.push_back(17'd0);
    @(posedge CLK); #1;
    CMD_TYPE = 2'b00; CMD_ADDR = 4'd7; CMD_WDATA = 8'h81; CMD_VLD = 1'b1;
    a0 = acc_cnt;
    for (int i = 0; i < 100 && acc_cnt == a0; i++) @(posedge CLK);
    #1;
    first_acc = acc_neg;
    CMD_ADDR = 4'd9; CMD_WDATA = 8'h42;
    push_frames(2'b00, 4'd9, 8'h42, 8'd0, 4'd0);
    exp_rsp_q.push_back(17'd0);
    a0 = acc_cnt;
    for (int i = 0; i < 100 && acc_cnt == a0; i++) @(posedge CLK);
    #1 CMD_VLD = 1'b0;
    check_val("acc_interval", acc_neg - first_acc, 32'd5);
    wait_rsp_empty();

    // Random commands with random replies (short replies time out).
    for (int k = 0; k < 6; k++)
      run_cmd(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
              8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)), $urandom_range(1, 2),
              8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));

    // Reset in the middle of SEND: abort, no response.
    TX_BUSY = 1'b1;
    issue_cmd(2'b10, 4'd0, 8'h11, 8'h22, 4'd3);
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    #1;
    check_val("midrst_tx_vld", {31'd0, TX_D_VLD}, 32'd0);
    check_val("midrst_tx_data", {24'd0, TX_P_DATA}, 32'd0);
    check_val("midrst_busy", {31'd0, BUSY}, 32'd0);
    check_val("midrst_rsp_vld", {31'd0, RSP_VLD}, 32'd0);
    check_val("midrst_rsp_data", {16'd0, RSP_DATA}, 32'd0);
    check_val("midrst_cmd_rdy", {31'd0, CMD_RDY}, 32'd1);
    exp_tx_q.delete();
    repeat (2) @(posedge CLK);
    #1 TX_BUSY = 1'b0; RST = 1'b1;
    run_cmd(2'b00, 4'd3, 8'hA5, 8'd0, 4'd0, 0, 8'h00, 8'h00);
    repeat (20) @(posedge CLK);

    check_val("tx_q_left", exp_tx_q.size(), 32'd0);
    check_val("rsp_q_left", exp_rsp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
